// File: rtl/stim_resp_driver.sv
// Drive/capture end of a DUT's i/o interface: applies a 4-bit vector, waits SETTLE_CYCLES,
// captures the 5-bit response and reports it. Optional STABILITY_CHECK_EN adds a double sample.
module stim_resp_driver #(
  parameter int SETTLE_CYCLES = 8,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [3:0]       vec_in,
  input  logic [4:0]       exp_in,
  output logic [3:0]       drv_i,
  input  logic [4:0]       dut_o,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [4:0]       resp_data,
  output logic             mismatch,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
`ifdef STABILITY_CHECK_EN
  ,
  output logic             unstable
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    CAPTURE  = 3'd2,
    CAPTURE2 = 3'd3,
    REPORT   = 3'd4
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [4:0] exp_q;
  logic       err_sat;

  assign vec_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign err_sat   = &err_count;

`ifdef STABILITY_CHECK_EN
  logic [4:0] samp1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      exp_q      <= '0;
      drv_i      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      mismatch   <= 1'b0;
      err_count  <= '0;
`ifdef STABILITY_CHECK_EN
      samp1      <= '0;
      unstable   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (vec_valid) begin
            drv_i <= vec_in;
            exp_q <= exp_in;
            cnt   <= CNT_INIT;
            state <= SETTLE;
          end
        end
        // counter is loaded with SETTLE_CYCLES-1 so SETTLE spans exactly SETTLE_CYCLES edges
        SETTLE: begin
          if (cnt == 8'd0) state <= CAPTURE;
          else             cnt   <= cnt - 8'd1;
        end
`ifdef STABILITY_CHECK_EN
        CAPTURE: begin
          samp1 <= dut_o;
          state <= CAPTURE2;
        end
        CAPTURE2: begin
          resp_data  <= dut_o;
          mismatch   <= (dut_o != exp_q);
          unstable   <= (dut_o != samp1);
          resp_valid <= 1'b1;
          // one increment per bad vector, whether mismatching, unstable or both
          if (((dut_o != exp_q) || (dut_o != samp1)) && !err_sat)
            err_count <= err_count + 1'b1;
          state <= REPORT;
        end
`else
        CAPTURE: begin
          resp_data  <= dut_o;
          mismatch   <= (dut_o != exp_q);
          resp_valid <= 1'b1;
          if ((dut_o != exp_q) && !err_sat)
            err_count <= err_count + 1'b1;
          state <= REPORT;
        end
`endif
        REPORT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_resp_driver.sv
// Directed bench for stim_resp_driver: main instance (8 settle, 8-bit counter) and a
// boundary instance (1 settle, 2-bit counter) driving a small behavioural DUT model.
module tb_stim_resp_driver;

`ifdef STABILITY_CHECK_EN
  localparam int LAT  = 10;
  localparam int LAT2 = 3;
`else
  localparam int LAT  = 9;
  localparam int LAT2 = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vec_valid, vec_ready, resp_valid, resp_ready, mismatch, busy, tog;
  logic [3:0] vec_in, drv_i;
  logic [4:0] exp_in, dut_o, resp_data;
  logic [7:0] err_count;

  logic       vec_valid2, vec_ready2, resp_valid2, mismatch2, busy2;
  logic [3:0] vec_in2, drv_i2;
  logic [4:0] exp_in2, dut_o2, resp_data2;
  logic [1:0] err_count2;
`ifdef STABILITY_CHECK_EN
  logic       unstable, unstable2;
`endif

  int nvec = 0;
  int nerr = 0;
  int n;

  always #5 clk = ~clk;

  // behavioural DUT: {o0,o1,o2[1],o2[0],o3}
  function automatic logic [4:0] model(input logic [3:0] i);
    return {i[0] & i[1], i[2] | i[3], i[3] ^ i[2], i[1] ^ i[0], ^i};
  endfunction

  assign dut_o  = model(drv_i) ^ {4'b0000, tog};
  assign dut_o2 = model(drv_i2);

  stim_resp_driver #(.SETTLE_CYCLES(8), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_in(vec_in), .exp_in(exp_in), .drv_i(drv_i), .dut_o(dut_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mismatch(mismatch), .busy(busy), .err_count(err_count)
`ifdef STABILITY_CHECK_EN
    , .unstable(unstable)
`endif
  );

  stim_resp_driver #(.SETTLE_CYCLES(1), .ERR_W(2)) u_bnd (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid2), .vec_ready(vec_ready2),
    .vec_in(vec_in2), .exp_in(exp_in2), .drv_i(drv_i2), .dut_o(dut_o2),
    .resp_valid(resp_valid2), .resp_ready(1'b1), .resp_data(resp_data2),
    .mismatch(mismatch2), .busy(busy2), .err_count(err_count2)
`ifdef STABILITY_CHECK_EN
    , .unstable(unstable2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // called at a negedge with vec_ready high; returns at the negedge after the accept edge
  task automatic offer(input logic [3:0] v, input logic [4:0] e);
    vec_valid = 1'b1; vec_in = v; exp_in = e;
    @(posedge clk); @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic offer2(input logic [3:0] v, input logic [4:0] e);
    vec_valid2 = 1'b1; vec_in2 = v; exp_in2 = e;
    @(posedge clk); @(negedge clk);
    vec_valid2 = 1'b0;
  endtask

  task automatic wait_resp(output int cnt);
    cnt = 0;
    while (!resp_valid && cnt < 40) begin @(negedge clk); cnt++; end
  endtask

  task automatic wait_resp2(output int cnt);
    cnt = 0;
    while (!resp_valid2 && cnt < 40) begin @(negedge clk); cnt++; end
  endtask

  initial begin
    rst_n = 1'b0; tog = 1'b0;
    vec_valid = 1'b0; vec_in = '0; exp_in = '0; resp_ready = 1'b0;
    vec_valid2 = 1'b0; vec_in2 = '0; exp_in2 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vec_ready", vec_ready, 1);
    chk("rst_drv_i", drv_i, 4'h0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mismatch", mismatch, 0);

    // reset in the middle of SETTLE aborts without a report
    offer(4'b1010, 5'b00000);
    chk("mid_drv_i", drv_i, 4'b1010);
    chk("mid_busy", busy, 1);
    chk("mid_vec_ready", vec_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_drv_i", drv_i, 4'h0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_vec_ready", vec_ready, 1);
    repeat (12) @(negedge clk);
    chk("abort_no_report", resp_valid, 0);

    // basic match
    offer(4'b0011, 5'b10000);
    chk("basic_drv_i", drv_i, 4'b0011);
    wait_resp(n);
    chk("basic_latency", n, LAT);
    chk("basic_resp_data", resp_data, 5'b10000);
    chk("basic_mismatch", mismatch, 0);
    chk("basic_err_count", err_count, 0);
`ifdef STABILITY_CHECK_EN
    chk("basic_unstable", unstable, 0);
`endif
    // handshake with a vector already offered: not accepted in the same cycle
    vec_valid = 1'b1; vec_in = 4'b0101; exp_in = 5'b01110; resp_ready = 1'b1;
    @(negedge clk);
    chk("hs_resp_valid", resp_valid, 0);
    chk("hs_vec_ready", vec_ready, 1);
    chk("hs_no_accept", drv_i, 4'b0011);
    resp_ready = 1'b0;
    @(negedge clk);
    vec_valid = 1'b0;
    chk("p2_drv_i", drv_i, 4'b0101);
    wait_resp(n);
    chk("p2_latency", n, LAT);
    chk("p2_resp_data", resp_data, 5'b01110);
    chk("p2_mismatch", mismatch, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("p2_resp_valid_low", resp_valid, 0);

    // mismatch
    offer(4'b1111, 5'b00000);
    wait_resp(n);
    chk("mis_latency", n, LAT);
    chk("mis_resp_data", resp_data, 5'b11000);
    chk("mis_mismatch", mismatch, 1);
    chk("mis_err_count", err_count, 1);

    // backpressure: result held, vector pulses ignored
    for (int k = 0; k < 5; k++) begin
      vec_valid = k[0]; vec_in = 4'b0000; exp_in = 5'b00000;
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, 5'b11000);
      chk("bp_mismatch", mismatch, 1);
      chk("bp_vec_ready", vec_ready, 0);
      chk("bp_drv_i", drv_i, 4'b1111);
    end
    vec_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready", vec_ready, 1);
    chk("bp_err_count", err_count, 1);
    chk("bp_drv_hold", drv_i, 4'b1111);

`ifdef STABILITY_CHECK_EN
    // output changes between the two capture edges
    offer(4'b0011, 5'b10001);
    repeat (9) @(negedge clk);
    chk("stab_first_edge", resp_valid, 0);
    tog = 1'b1;
    @(negedge clk);
    chk("stab_resp_valid", resp_valid, 1);
    chk("stab_resp_data", resp_data, 5'b10001);
    chk("stab_unstable", unstable, 1);
    chk("stab_mismatch", mismatch, 0);
    chk("stab_err_count", err_count, 2);
    tog = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
`endif

    // boundary instance: 1-cycle settle, 2-bit saturating counter
    for (int k = 0; k < 5; k++) begin
      offer2(4'b1111, 5'b00000);
      wait_resp2(n);
      chk("bnd_latency", n, LAT2);
      chk("bnd_resp_data", resp_data2, 5'b11000);
      chk("bnd_mismatch", mismatch2, 1);
      chk("bnd_err_count", err_count2, (k < 3) ? k + 1 : 3);
      @(negedge clk);
      chk("bnd_vec_ready", vec_ready2, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
